// File: rtl/pipelined_shift_unit_pkg.sv
// Shared mode encodings and helpers for the pipelined shifter/rotator.
// The mode values match those used by the ALU decoder.
package pipelined_shift_unit_pkg;

  typedef enum logic [2:0] {
    MODE_ROL = 3'b000,
    MODE_SLL = 3'b001,
    MODE_ROR = 3'b010,
    MODE_SRL = 3'b011,
    MODE_SRA = 3'b100
  } shift_mode_e;

  function automatic logic mode_is_legal(input logic [2:0] mode);
    return mode <= MODE_SRA;
  endfunction

endpackage

// File: rtl/pipelined_shift_unit_stage.sv
// One log-shift level: conditional shift/rotate by DIST, plus the stage
// pipeline register, which loads only when the stage is allowed to advance.
module shift_stage
  import pipelined_shift_unit_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DIST        = 1,
  parameter int unsigned SHAMT_WIDTH = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_adv,
  input  logic                   i_valid,
  input  logic [WIDTH-1:0]       i_data,
  input  logic [SHAMT_WIDTH-1:0] i_shamt,
  input  logic [2:0]             i_mode,
  input  logic                   i_err,
  output logic                   o_valid,
  output logic [WIDTH-1:0]       o_data,
  output logic [SHAMT_WIDTH-1:0] o_shamt,
  output logic [2:0]             o_mode,
  output logic                   o_err
);

  localparam int unsigned BIT = $clog2(DIST);

  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_next;

  logic                   r_valid;
  logic [WIDTH-1:0]       r_data;
  logic [SHAMT_WIDTH-1:0] r_shamt;
  logic [2:0]             r_mode;
  logic                   r_err;

  // Illegal modes fall through to the default arm, so their data is never shifted.
  always_comb begin
    w_shifted = i_data;
    case (i_mode)
      MODE_ROL: w_shifted = {i_data[WIDTH-DIST-1:0], i_data[WIDTH-1:WIDTH-DIST]};
      MODE_SLL: w_shifted = i_data << DIST;
      MODE_ROR: w_shifted = {i_data[DIST-1:0], i_data[WIDTH-1:DIST]};
      MODE_SRL: w_shifted = i_data >> DIST;
      MODE_SRA: w_shifted = WIDTH'($signed(i_data) >>> DIST);
      default:  w_shifted = i_data;
    endcase
    w_next = i_shamt[BIT] ? w_shifted : i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_shamt <= '0;
      r_mode  <= '0;
      r_err   <= 1'b0;
    end else if (i_adv) begin
      r_valid <= i_valid;
      r_data  <= w_next;
      r_shamt <= i_shamt;
      r_mode  <= i_mode;
      r_err   <= i_err;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_shamt = r_shamt;
  assign o_mode  = r_mode;
  assign o_err   = r_err;

endmodule

// File: rtl/pipelined_shift_unit.sv
// Pipelined SLL/SRL/SRA/ROL/ROR unit, one log-shift level per stage, with
// valid/ready on both sides. The top holds only the advance chain and wiring.
module pipelined_shift_unit
  import pipelined_shift_unit_pkg::*;
#(
  parameter  int unsigned WIDTH       = 16,
  localparam int unsigned SHAMT_WIDTH = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SHAMT_WIDTH-1:0] in_shamt,
  input  logic [2:0]             in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_err
);

  // Index 0 is the input port; index k+1 is the register of stage k.
  logic                   w_v     [SHAMT_WIDTH+1];
  logic [WIDTH-1:0]       w_data  [SHAMT_WIDTH+1];
  logic [SHAMT_WIDTH-1:0] w_shamt [SHAMT_WIDTH+1];
  logic [2:0]             w_mode  [SHAMT_WIDTH+1];
  logic                   w_err   [SHAMT_WIDTH+1];
  logic [SHAMT_WIDTH-1:0] w_adv;
  logic                   w_unused_tail;

  assign w_v[0]     = in_valid;
  assign w_data[0]  = in_data;
  assign w_shamt[0] = in_shamt;
  assign w_mode[0]  = in_mode;
  assign w_err[0]   = !mode_is_legal(in_mode);

  // A stage advances when it is empty or its successor advances.
  always_comb begin
    w_adv = '0;
    w_adv[SHAMT_WIDTH-1] = out_ready || !w_v[SHAMT_WIDTH];
    for (int unsigned k = SHAMT_WIDTH - 1; k > 0; k--) begin
      w_adv[k-1] = !w_v[k] || w_adv[k];
    end
  end

  for (genvar k = 0; k < SHAMT_WIDTH; k++) begin : g_stage
    shift_stage #(
      .WIDTH       (WIDTH),
      .DIST        (2 ** k),
      .SHAMT_WIDTH (SHAMT_WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_adv   (w_adv[k]),
      .i_valid (w_v[k]),
      .i_data  (w_data[k]),
      .i_shamt (w_shamt[k]),
      .i_mode  (w_mode[k]),
      .i_err   (w_err[k]),
      .o_valid (w_v[k+1]),
      .o_data  (w_data[k+1]),
      .o_shamt (w_shamt[k+1]),
      .o_mode  (w_mode[k+1]),
      .o_err   (w_err[k+1])
    );
  end

  assign w_unused_tail = ^{w_shamt[SHAMT_WIDTH], w_mode[SHAMT_WIDTH]};

  assign in_ready  = w_adv[0];
  assign out_valid = w_v[SHAMT_WIDTH];
  assign out_data  = w_data[SHAMT_WIDTH];
  assign out_err   = w_err[SHAMT_WIDTH];

endmodule

// File: tb/tb_pipelined_shift_unit.sv
// Directed bench for pipelined_shift_unit (WIDTH=16): reset, mode sweep,
// boundary shifts, streaming, backpressure and illegal-mode handling.
module tb_pipelined_shift_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_shamt;
  logic [2:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_err;

  typedef struct {
    logic [15:0] d;
    logic        e;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc      = 0;
  logic        lat_chk  = 1'b0;
  logic        prev_stall = 1'b0;
  logic [15:0] held_d;

  pipelined_shift_unit #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] ref_op(input logic [15:0] d, input logic [3:0] s,
                                         input logic [2:0] m);
    logic [31:0] dd;
    logic [31:0] t;
    logic [15:0] r;
    dd = {d, d};
    case (m)
      3'b000:  begin t = dd << s; r = t[31:16]; end
      3'b001:  r = d << s;
      3'b010:  begin t = dd >> s; r = t[15:0]; end
      3'b011:  r = d >> s;
      3'b100:  r = 16'($signed(d) >>> s);
      default: r = d;
    endcase
    return {(m > 3'b100), r};
  endfunction

  // Output monitor: held-data stability and in-order scoreboard compare.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (out_valid && !out_ready) begin
        if (prev_stall) check_eq("hold_data", out_data, held_d);
        held_d     = out_data;
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("spurious_out", out_valid, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("out_data", out_data, e.d);
          check_eq("out_err", out_err, e.e);
          if (lat_chk) check_eq("latency", cyc - e.cyc, 4);
        end
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic [3:0] s, input logic [2:0] m,
                      input logic [15:0] ed, input logic ee);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = s;
    in_mode  = m;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{ed, ee, cyc});
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!acc) check_eq("send_timeout", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [15:0] d, input logic [3:0] s, input logic [2:0] m);
    logic [16:0] r;
    r = ref_op(d, s, m);
    send(d, s, m, r[15:0], r[16]);
  endtask

  task automatic drain();
    for (int c = 0; c < 100 && sb.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    check_eq("drain_empty", sb.size(), 0);
  endtask

  logic [15:0] bp_d [8];
  logic [3:0]  bp_s [8];
  logic [2:0]  bp_m [8];

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_mode   = '0;
    out_ready = 1'b1;
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_err", out_err, 0);
    check_eq("rst_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Mode sweep, 0x8421 by 4.
    lat_chk = 1'b1;
    send(16'h8421, 4'd4, 3'b000, 16'h4218, 1'b0);
    send(16'h8421, 4'd4, 3'b001, 16'h4210, 1'b0);
    send(16'h8421, 4'd4, 3'b010, 16'h1842, 1'b0);
    send(16'h8421, 4'd4, 3'b011, 16'h0842, 1'b0);
    send(16'h8421, 4'd4, 3'b100, 16'hF842, 1'b0);
    drain();

    // Boundary shifts.
    for (int m = 0; m < 5; m++) send(16'hA5C3, 4'd0, 3'(m), 16'hA5C3, 1'b0);
    send(16'h8000, 4'd15, 3'b100, 16'hFFFF, 1'b0);
    send(16'h0001, 4'd15, 3'b000, 16'h8000, 1'b0);
    send(16'h0001, 4'd15, 3'b010, 16'h0002, 1'b0);
    drain();

    // Illegal mode, then a legal op.
    send(16'hBEEF, 4'd3, 3'b111, 16'hBEEF, 1'b1);
    send(16'h0001, 4'd3, 3'b001, 16'h0008, 1'b0);
    drain();

    // Back-to-back streaming against the model.
    for (int i = 0; i < 20; i++)
      send_model(16'($urandom), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
    drain();

    // Backpressure: 8 ops offered, out_ready low for 6 cycles.
    lat_chk = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bp_d[i] = 16'($urandom);
      bp_s[i] = 4'($urandom_range(0, 15));
      bp_m[i] = 3'($urandom_range(0, 4));
    end
    out_ready = 1'b0;
    begin
      int idx;
      logic [16:0] r;
      idx = 0;
      for (int c = 0; c < 60 && (idx < 8 || c <= 6); c++) begin
        if (c == 6) begin
          check_eq("bp_accepted", idx, 4);
          check_eq("bp_in_ready", in_ready, 0);
          out_ready = 1'b1;
        end
        if (idx < 8) begin
          in_valid = 1'b1;
          in_data  = bp_d[idx];
          in_shamt = bp_s[idx];
          in_mode  = bp_m[idx];
        end else begin
          in_valid = 1'b0;
        end
        @(negedge clk);
        if (in_valid && in_ready) begin
          r = ref_op(bp_d[idx], bp_s[idx], bp_m[idx]);
          sb.push_back('{r[15:0], r[16], cyc});
          idx++;
        end
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      check_eq("bp_all_accepted", idx, 8);
    end
    drain();

    // Reset with three ops in flight.
    lat_chk = 1'b1;
    send(16'h1234, 4'd1, 3'b001, 16'h2468, 1'b0);
    send(16'h5678, 4'd2, 3'b011, 16'h159E, 1'b0);
    send(16'h9ABC, 4'd3, 3'b000, 16'hD5E4, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    check_eq("midrst_out_data", out_data, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check_eq("post_rst_idle", out_valid, 0);
    send(16'h00F0, 4'd4, 3'b010, 16'h000F, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
